wb_stage_fwd: RTL and testbench

WB_STAGE_FWD -- requirements
Module: wb_stage_fwd

---
 rtl/wb_stage_fwd_pkg.sv | 21 ++
 rtl/wb_stage_fwd_hist.sv | 54 +++++
 rtl/wb_stage_fwd.sv | 111 +++++++++++
 tb/tb_wb_stage_fwd.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_fwd_pkg.sv
// Shared writeback-pipeline definitions: source-select encodings and control-bit layout.
// No logic; imported by the writeback stage and its forwarding history.
package wb_stage_fwd_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_PC   = 2'b01,
    SRC_COND = 2'b10,
    SRC_MEM  = 2'b11
  } wb_src_e;

  localparam int CTRL_W      = 3;
  localparam int CTRL_REG_WR = 2;
  localparam int CTRL_SEL_HI = 1;
  localparam int CTRL_SEL_LO = 0;

  function automatic wb_src_e ctrl_src(input logic [CTRL_W-1:0] ctrl);
    return wb_src_e'(ctrl[CTRL_SEL_HI:CTRL_SEL_LO]);
  endfunction

endpackage

// File: rtl/wb_stage_fwd_hist.sv
// Retired-write history: shift buffer of {valid, addr, data}, entry 0 newest.
// Lookup is combinational; a push takes effect on the next clock edge.
// No backpressure; the caller gates push with its own stall.
module fwd_hist_buf
  import wb_stage_fwd_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RAW       = 3,
  parameter int FWD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [RAW-1:0]    push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [RAW-1:0]    q_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  typedef struct packed {
    logic              vld;
    logic [RAW-1:0]    addr;
    logic [DATA_W-1:0] data;
  } hist_ent_t;

  hist_ent_t hist [FWD_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else if (push) begin
      hist[0] <= '{vld: 1'b1, addr: push_addr, data: push_data};
      for (int i = 1; i < FWD_DEPTH; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  // Scan oldest to newest so a newer match overrides an older one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (hist[i].vld && (hist[i].addr == q_addr)) begin
        hit      = 1'b1;
        hit_data = hist[i].data;
      end
    end
  end

endmodule

// File: rtl/wb_stage_fwd.sv
// Writeback stage with register-file write port, forwarding lookup and retire counter.
// Latency: one cycle from inputs to write port; forwarding lookup is combinational.
// Backpressure: stall holds the stage, history and counter; flush kills the stage valid only.
module wb_stage_fwd
  import wb_stage_fwd_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RAW       = 3,
  parameter int FWD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] pc_inc2,
  input  logic [DATA_W-1:0] mr_data,
  input  logic              ex_cond,
  input  logic [RAW-1:0]    dst_reg,
  input  logic [2:0]        in_WB_control,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [RAW-1:0]    q_addr,
  output logic              reg_write,
  output logic [RAW-1:0]    out_dst_reg,
  output logic [DATA_W-1:0] rw_data,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [15:0]       retire_cnt
);

  typedef struct packed {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [RAW-1:0]    dst;
    logic              ex_cond;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] mr;
  } stage_t;

  stage_t            stage;
  logic              hist_push;
  logic              hist_hit;
  logic [DATA_W-1:0] hist_data;

  // Flush only clears valid while stalled; data fields stay put so the held view is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (!stall) begin
      stage <= '{vld:     in_valid & ~flush,
                 ctrl:    in_WB_control,
                 dst:     dst_reg,
                 ex_cond: ex_cond,
                 alu:     alu_out,
                 pc:      pc_inc2,
                 mr:      mr_data};
    end else if (flush) begin
      stage.vld <= 1'b0;
    end
  end

  assign reg_write   = stage.vld & stage.ctrl[CTRL_REG_WR];
  assign out_dst_reg = stage.dst;

  always_comb begin
    rw_data = stage.alu;
    case (ctrl_src(stage.ctrl))
      SRC_MEM:  rw_data = stage.mr;
      SRC_COND: rw_data = {{(DATA_W-1){1'b0}}, stage.ex_cond};
      SRC_PC:   rw_data = stage.pc;
      default:  rw_data = stage.alu;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (!stall && stage.vld) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end

  assign hist_push = ~stall & reg_write;

  fwd_hist_buf #(
    .DATA_W   (DATA_W),
    .RAW      (RAW),
    .FWD_DEPTH(FWD_DEPTH)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .push     (hist_push),
    .push_addr(out_dst_reg),
    .push_data(rw_data),
    .q_addr   (q_addr),
    .hit      (hist_hit),
    .hit_data (hist_data)
  );

  // The in-flight write is newer than anything already retired.
  always_comb begin
    fwd_hit  = hist_hit;
    fwd_data = hist_data;
    if (reg_write && (out_dst_reg == q_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = rw_data;
    end
  end

endmodule

// File: tb/tb_wb_stage_fwd.sv
// Directed bench for wb_stage_fwd: scoreboard on the write port, explicit checks on forwarding,
// stall/flush, counter wrap and asynchronous reset.
module tb_wb_stage_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_out, pc_inc2, mr_data;
  logic        ex_cond;
  logic [2:0]  dst_reg;
  logic [2:0]  in_WB_control;
  logic        in_valid, stall, flush;
  logic [2:0]  q_addr;
  logic        reg_write;
  logic [2:0]  out_dst_reg;
  logic [15:0] rw_data;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [15:0] retire_cnt;

  typedef struct {
    logic        rw;
    logic [2:0]  dst;
    logic [15:0] data;
  } exp_t;

  exp_t        sb [$];
  int          total = 0;
  int          bad   = 0;
  logic        sv;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  wb_stage_fwd #(.DATA_W(16), .RAW(3), .FWD_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_out      (alu_out),
    .pc_inc2      (pc_inc2),
    .mr_data      (mr_data),
    .ex_cond      (ex_cond),
    .dst_reg      (dst_reg),
    .in_WB_control(in_WB_control),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .q_addr       (q_addr),
    .reg_write    (reg_write),
    .out_dst_reg  (out_dst_reg),
    .rw_data      (rw_data),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .retire_cnt   (retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wb_value(input logic [2:0] c, input logic ec,
                                           input logic [15:0] a, input logic [15:0] p,
                                           input logic [15:0] m);
    case (c[1:0])
      2'b11:   return m;
      2'b10:   return {15'd0, ec};
      2'b01:   return p;
      default: return a;
    endcase
  endfunction

  // Advance one edge; expected counter and stage valid follow the inputs present at the edge.
  task automatic step();
    if (!stall && sv) exp_cnt = exp_cnt + 16'd1;
    sv = stall ? (flush ? 1'b0 : sv) : (in_valid & ~flush);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sb(input string tag);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
    end else begin
      total--;
      e = sb.pop_front();
      chk({tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
      chk({tag, ".dst"}, 32'(out_dst_reg), 32'(e.dst));
      chk({tag, ".rw_data"}, 32'(rw_data), 32'(e.data));
    end
  endtask

  task automatic issue(input string tag, input logic v, input logic [2:0] c, input logic [2:0] d,
                       input logic [15:0] a, input logic [15:0] p, input logic [15:0] m,
                       input logic ec);
    exp_t e;
    in_valid = v; in_WB_control = c; dst_reg = d;
    alu_out = a; pc_inc2 = p; mr_data = m; ex_cond = ec;
    stall = 1'b0; flush = 1'b0;
    e.rw = v & c[2]; e.dst = d; e.data = wb_value(c, ec, a, p, m);
    sb.push_back(e);
    step();
    chk_sb(tag);
  endtask

  task automatic hold_step(input logic f);
    stall = 1'b1; flush = f;
    in_valid = 1'b1; in_WB_control = 3'b111; dst_reg = 3'd0;
    alu_out = 16'hFFFF; pc_inc2 = 16'hFFFF; mr_data = 16'hFFFF; ex_cond = 1'b1;
    step();
  endtask

  task automatic fq(input string tag, input logic [2:0] a, input logic h, input logic [15:0] d);
    q_addr = a;
    #1;
    chk({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(h));
    chk({tag, ".fwd_data"}, 32'(fwd_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1; sv = 1'b0; exp_cnt = 16'd0;
    in_valid = 1'b1; in_WB_control = 3'b111; dst_reg = 3'd5; q_addr = 3'd5;
    alu_out = 16'h1111; pc_inc2 = 16'h2222; mr_data = 16'h3333; ex_cond = 1'b1;
    stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.reg_write", 32'(reg_write), 32'd0);
    chk("rst.dst", 32'(out_dst_reg), 32'd0);
    chk("rst.rw_data", 32'(rw_data), 32'd0);
    chk("rst.fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst.fwd_data", 32'(fwd_data), 32'd0);
    chk("rst.retire_cnt", 32'(retire_cnt), 32'd0);
    rst = 1'b0;

    // Memory-sourced write to r5, then a bubble to let it retire.
    issue("mem_wr", 1'b1, 3'b111, 3'd5, 16'h1111, 16'h2222, 16'h1234, 1'b0);
    chk("mem_wr.cnt", 32'(retire_cnt), 32'd0);
    issue("bubble0", 1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("bubble0.cnt", 32'(retire_cnt), 32'd1);
    fq("hist_r5", 3'd5, 1'b1, 16'h1234);

    // Condition source, then a non-writing instruction must not enter history.
    issue("cond_wr", 1'b1, 3'b110, 3'd1, 16'h1111, 16'h2222, 16'h3333, 1'b1);
    issue("no_wr", 1'b1, 3'b011, 3'd4, 16'h1111, 16'h2222, 16'h3333, 1'b0);
    fq("no_wr.stage", 3'd4, 1'b0, 16'h0000);
    issue("bubble1", 1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    fq("hist_r1", 3'd1, 1'b1, 16'h0001);
    fq("hist_r5_kept", 3'd5, 1'b1, 16'h1234);
    chk("bubble1.cnt", 32'(retire_cnt), 32'(exp_cnt));

    // Newest-wins priority and ageing out.
    issue("r2_a", 1'b1, 3'b100, 3'd2, 16'hAAAA, 16'h0000, 16'h0000, 1'b0);
    issue("r2_b", 1'b1, 3'b100, 3'd2, 16'hBBBB, 16'h0000, 16'h0000, 1'b0);
    issue("r3", 1'b1, 3'b101, 3'd3, 16'h0000, 16'h0003, 16'h0000, 1'b0);
    fq("stage_r3", 3'd3, 1'b1, 16'h0003);
    fq("newest_r2", 3'd2, 1'b1, 16'hBBBB);
    issue("bubble2", 1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    fq("retired_r2", 3'd2, 1'b1, 16'hBBBB);
    issue("r6", 1'b1, 3'b100, 3'd6, 16'h0606, 16'h0000, 16'h0000, 1'b0);
    issue("bubble3", 1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    fq("aged_r2", 3'd2, 1'b0, 16'h0000);

    // Three-cycle stall with a valid write held in the stage.
    issue("r7", 1'b1, 3'b100, 3'd7, 16'h7777, 16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      hold_step(1'b0);
      chk("stall.reg_write", 32'(reg_write), 32'd1);
      chk("stall.dst", 32'(out_dst_reg), 32'd7);
      chk("stall.rw_data", 32'(rw_data), 32'h7777);
      chk("stall.cnt", 32'(retire_cnt), 32'(exp_cnt));
      fq("stall.hist_r6", 3'd6, 1'b1, 16'h0606);
    end
    issue("release", 1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("release.cnt", 32'(retire_cnt), 32'(exp_cnt));
    fq("release.r7", 3'd7, 1'b1, 16'h7777);
    fq("release.r6", 3'd6, 1'b1, 16'h0606);
    fq("release.r3_aged", 3'd3, 1'b0, 16'h0000);

    // Flush while stalled kills the valid write; fields and history stay.
    issue("r3_f", 1'b1, 3'b100, 3'd3, 16'h3333, 16'h0000, 16'h0000, 1'b0);
    hold_step(1'b1);
    chk("flush.reg_write", 32'(reg_write), 32'd0);
    chk("flush.dst", 32'(out_dst_reg), 32'd3);
    chk("flush.rw_data", 32'(rw_data), 32'h3333);
    chk("flush.cnt", 32'(retire_cnt), 32'(exp_cnt));
    fq("flush.r3", 3'd3, 1'b0, 16'h0000);
    issue("post_flush", 1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("post_flush.cnt", 32'(retire_cnt), 32'(exp_cnt));
    fq("post_flush.r3", 3'd3, 1'b0, 16'h0000);
    fq("post_flush.r7", 3'd7, 1'b1, 16'h7777);

    // Retire non-writing instructions until the counter sits at 0xFFFF, then wrap.
    in_valid = 1'b1; in_WB_control = 3'b000; dst_reg = 3'd0;
    alu_out = 16'h0000; pc_inc2 = 16'h0000; mr_data = 16'h0000; ex_cond = 1'b0;
    stall = 1'b0; flush = 1'b0;
    for (int n = 0; n < 70000 && exp_cnt != 16'hFFFF; n++) step();
    chk("cnt_ffff", 32'(retire_cnt), 32'h0000FFFF);
    step();
    chk("cnt_wrap", 32'(retire_cnt), 32'h00000000);

    // Asynchronous reset in the middle of a cycle with a write in the stage.
    issue("pre_rst", 1'b1, 3'b100, 3'd2, 16'h5A5A, 16'h0000, 16'h0000, 1'b0);
    q_addr = 3'd2;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.reg_write", 32'(reg_write), 32'd0);
    chk("arst.dst", 32'(out_dst_reg), 32'd0);
    chk("arst.rw_data", 32'(rw_data), 32'd0);
    chk("arst.fwd_hit", 32'(fwd_hit), 32'd0);
    chk("arst.fwd_data", 32'(fwd_data), 32'd0);
    chk("arst.cnt", 32'(retire_cnt), 32'd0);
    stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("arst_hold.cnt", 32'(retire_cnt), 32'd0);
    rst = 1'b0; sv = 1'b0; exp_cnt = 16'd0;
    issue("after_rst", 1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    fq("after_rst.r7", 3'd7, 1'b0, 16'h0000);
    chk("after_rst.cnt", 32'(retire_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
